pipeline_hazard_controller: RTL

- Parametrised hazard controller for the 5-stage MIPS pipeline; next generation of the jump-only hazard handler.
- Covers four hazards: jumps resolved in ID, taken branches resolved in EX, load-use data hazards, and multi-cycle EXE busy.
- Issues per-stage stall and flush controls to PC, IF/ID and ID/EX, holds them for configurable cycle counts, and keeps saturating event counters for the debug unit.

---
 rtl/pipeline_hazard_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//   Hazard controller for a 5-stage MIPS pipeline. Handles jumps resolved in ID,
//   taken branches resolved in EX, load-use data hazards and a multi-cycle EX
//   unit that reports busy. The first cycle of every hazard is answered
//   combinationally (Mealy). Any further cycles come from a small FSM with a
//   down-counter. Saturating event counters are kept for the debug unit.
//
// Ports
//   clk, reset              : rising-edge clock, async active-high reset
//   is_jump                 : jump decoded in ID this cycle
//   branch_taken            : branch in EX resolved taken this cycle
//   id_rs, id_rt, id_uses_rt: source registers of the ID instruction
//   ex_mem_read, ex_rt      : EX instruction is a load, and its destination
//   exe_busy                : multi-cycle EX unit not finished
//   stall_pc/id/exe         : hold PC / IF/ID / ID/EX
//   flush_if_id/id_ex       : bubble IF/ID / ID/EX
//   stall_count/flush_count : saturating counts of stall_pc / flush_if_id cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int unsigned JUMP_FLUSH_CYCLES   = 1,
  parameter int unsigned BRANCH_FLUSH_CYCLES = 2,
  parameter int unsigned LOAD_USE_CYCLES     = 1,
  parameter int unsigned REG_ADDR_W          = 5,
  parameter int unsigned CNT_W               = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  is_jump,
  input  logic                  branch_taken,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  exe_busy,
  output logic                  stall_pc,
  output logic                  stall_id,
  output logic                  stall_exe,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FLUSH_J  = 3'd1;
  localparam logic [2:0] ST_FLUSH_B  = 3'd2;
  localparam logic [2:0] ST_STALL_LU = 3'd3;
  localparam logic [2:0] ST_BUSY     = 3'd4;

  // Cycles still owed after the first (combinational) cycle of each hazard.
  localparam logic [2:0] JUMP_LEFT   = 3'(JUMP_FLUSH_CYCLES - 1);
  localparam logic [2:0] BRANCH_LEFT = 3'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [2:0] LU_LEFT     = 3'(LOAD_USE_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] resume_q, resume_d;   // sequence frozen underneath BUSY
  logic [2:0] cnt_q, cnt_d;         // remaining cycles of the active sequence
  logic [2:0] cur_s;                // sequence state in effect this cycle
  logic       lu_s;
  logic       stall_pc_s, stall_id_s, stall_exe_s, flush_if_id_s, flush_id_ex_s;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;

  // Hazard detection, output decode and next-state selection.
  always_comb begin
    lu_s = ex_mem_read && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // Leaving BUSY resumes the frozen sequence in the same cycle.
    cur_s = (state_q == ST_BUSY) ? resume_q : state_q;

    stall_pc_s    = 1'b0;
    stall_id_s    = 1'b0;
    stall_exe_s   = 1'b0;
    flush_if_id_s = 1'b0;
    flush_id_ex_s = 1'b0;
    state_d       = cur_s;
    resume_d      = ST_IDLE;
    cnt_d         = cnt_q;

    if (exe_busy) begin
      // Full stall; the counter is held so the sequence resumes intact.
      stall_pc_s  = 1'b1;
      stall_id_s  = 1'b1;
      stall_exe_s = 1'b1;
      state_d     = ST_BUSY;
      resume_d    = cur_s;
    end else if (branch_taken) begin
      // A taken branch overrides (or restarts) any non-busy sequence.
      flush_if_id_s = 1'b1;
      flush_id_ex_s = 1'b1;
      state_d       = (BRANCH_LEFT != 3'd0) ? ST_FLUSH_B : ST_IDLE;
      cnt_d         = BRANCH_LEFT;
    end else begin
      case (cur_s)
        ST_IDLE: begin
          if (is_jump) begin
            flush_if_id_s = 1'b1;
            state_d       = (JUMP_LEFT != 3'd0) ? ST_FLUSH_J : ST_IDLE;
            cnt_d         = JUMP_LEFT;
          end else if (lu_s) begin
            stall_pc_s    = 1'b1;
            stall_id_s    = 1'b1;
            flush_id_ex_s = 1'b1;
            state_d       = (LU_LEFT != 3'd0) ? ST_STALL_LU : ST_IDLE;
            cnt_d         = LU_LEFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FLUSH_J: begin
          flush_if_id_s = 1'b1;
        end
        ST_FLUSH_B: begin
          // A jump seen here is on the wrong path and is ignored.
          flush_if_id_s = 1'b1;
          flush_id_ex_s = 1'b1;
        end
        ST_STALL_LU: begin
          stall_pc_s    = 1'b1;
          stall_id_s    = 1'b1;
          flush_id_ex_s = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase

      // Count down the continuing sequences; the cycle with cnt = 1 is the last.
      if ((cur_s == ST_FLUSH_J) || (cur_s == ST_FLUSH_B) || (cur_s == ST_STALL_LU)) begin
        if (cnt_q <= 3'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end else begin
        cnt_d = cnt_d;
      end
    end
  end

  // FSM state, frozen-sequence and down-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_IDLE;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (stall_pc_s && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
      if (flush_if_id_s && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 1'b1;
      end
    end
  end

  // Controls are forced low while reset is held, independent of the inputs.
  assign stall_pc    = stall_pc_s    & ~reset;
  assign stall_id    = stall_id_s    & ~reset;
  assign stall_exe   = stall_exe_s   & ~reset;
  assign flush_if_id = flush_if_id_s & ~reset;
  assign flush_id_ex = flush_id_ex_s & ~reset;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
